// File: rtl/cla_seq_subtractor.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit borrow-lookahead slice per clock.
// Handshake: start is accepted only in IDLE (ignored otherwise); done is a one-cycle pulse, no backpressure.
module cla_seq_subtractor #(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_r, b_r, work, work_nx;
  logic             br;
  logic             last;
  logic [3:0]       na, nb, g, p, d;
  logic [4:0]       c;

  // Borrow lookahead for the current nibble; every borrow is a flat sum of products of br.
  always_comb begin
    na   = a_r[4*int'(k) +: 4];
    nb   = b_r[4*int'(k) +: 4];
    g    = ~na & nb;
    p    = ~(na ^ nb);
    c[0] = br;
    c[1] = g[0] | (p[0] & br);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & br);
    d    = na ^ nb ^ c[3:0];
    work_nx = work;
    work_nx[4*int'(k) +: 4] = d;
  end

  assign last = (k == KW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    dbg_state = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      br   <= 1'b0;
      k    <= '0;
      work <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r <= a;
          b_r <= b;
          br  <= bin;
          k   <= '0;
        end
        RUN: begin
          work <= work_nx;
          br   <= c[4];
          k    <= last ? '0 : k + KW'(1);
          // Results publish only here, so partial nibbles never reach diff.
          if (last) begin
            diff <= work_nx;
            bout <= c[4];
            ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) & (work_nx[WIDTH-1] != a_r[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cla_seq_subtractor.md
Name: cla_seq_subtractor

Overview:
- Multi-cycle N-bit subtractor that computes diff = a − b − bin.
- Processes one 4-bit nibble per clock, LSB nibble first.
- Each nibble uses a borrow-lookahead slice, so the borrow within a nibble is resolved in one cycle.
- This is the subtract-direction counterpart of the team's 4-bit carry-lookahead adder. It serves datapaths that need wide subtraction with a start/done handshake rather than a wide combinational chain.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and ≥ 4.
- NIB, WIDTH/4, derived; number of nibble cycles. Not user-overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- bin  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while nibbles are being processed (RUN).
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  result; registered, held stable until the next completion.
- bout  output  1  borrow-out from the MSB nibble (unsigned a < b + bin).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state = IDLE; busy = 0, done = 0, diff = 0, bout = 0, ovf = 0; nibble counter = 0; operand and working registers = 0.
- Reset asserted mid-operation aborts the operation immediately. No done is produced, and diff, bout and ovf read 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start = 1.
  - Latch a, b and bin into internal registers.
  - Set nibble counter k = 0 and busy = 1.
- RUN: each edge processes nibble k, using bits [4k+3:4k] of the latched operands and the current borrow register br.
  - Per bit i: g_i = ~a_i & b_i; p_i = ~(a_i ^ b_i); d_i = a_i ^ b_i ^ br_i.
  - Borrow chain in lookahead form: br_0 = br; br_{i+1} = g_i | (p_i & br_i).
  - br_1 to br_4 are expanded as sum-of-products from br, not rippled.
  - Write the 4 d bits into the working result at nibble k.
  - Set br = br_4, then k = k + 1.
  - After the edge that processes k = NIB−1, go to DONE.
- RUN -> DONE edge:
  - Copy the working result to diff and the final br to bout.
  - Set ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched a and b.
  - busy = 0, done = 1.
- DONE -> IDLE: on the next edge unconditionally; done returns to 0.
- Latency: start accepted at edge E0; busy = 1 after E0; done = 1 after edge E0 + NIB, for exactly one cycle.
- Throughput: one operation every NIB + 2 cycles at best, since the next start is accepted in IDLE.
- start while busy or while done = 1 is ignored. Latched operands are unaffected.
- Changes on a, b or bin after the accepted start edge have no effect on the result.
- diff, bout and ovf change only on the RUN -> DONE edge. Partial nibbles are never visible on diff.
- Width rules: all arithmetic is modulo 2^WIDTH; bout is the true unsigned borrow. For WIDTH = 4: one RUN cycle, done after E0 + 1.

Test Plan:
- Basic subtract, WIDTH = 16: 0x1234 − 0x0034, bin = 0 -> diff 0x1200, bout 0, ovf 0; done high exactly 4 cycles after the start edge, busy high for those 4 cycles.
- Underflow: 0x0000 − 0x0001, bin = 0 -> diff 0xFFFF, bout 1, ovf 0. The borrow must propagate through all 4 nibbles.
- Signed overflow: 0x8000 − 0x0001 -> diff 0x7FFF, bout 0, ovf 1. Also 0x7FFF − 0xFFFF -> diff 0x8000, bout 1, ovf 1.
- Borrow-in across a nibble boundary: 0x0010 − 0x000F, bin = 1 -> diff 0x0000, bout 0. Also 0x0000 − 0x0000, bin = 1 -> diff 0xFFFF, bout 1.
- Handshake robustness: pulse start again 2 cycles into RUN with different operands, and change a/b during RUN.
  - Required: the first result is unchanged and only one done is produced.
  - A start in the cycle after done begins a new operation.
- Reset mid-op: assert rst_n = 0 asynchronously (between edges) during RUN cycle 2.
  - Required: busy, done, diff, bout and ovf go to 0 immediately, with no done after release.
  - A subsequent 0x00FF − 0x0001 -> diff 0x00FE.
